// File: rtl/stream_upsize.sv
// Packs T_DATA_RATIO narrow input beats into one wide output word with per-lane keep bits.
// A word closes early on s_last_i; the output register is a single-entry skid-free stage.
module stream_upsize #(
    parameter int T_DATA_WIDTH = 4,
    parameter int T_DATA_RATIO = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [T_DATA_WIDTH-1:0] s_data_i,
    input  logic                    s_last_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o [T_DATA_RATIO-1:0],
    output logic [T_DATA_RATIO-1:0] m_keep_o,
    output logic                    m_last_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i
);

    localparam int IDX_W = (T_DATA_RATIO > 1) ? $clog2(T_DATA_RATIO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(T_DATA_RATIO - 1);

    logic [IDX_W-1:0]        idx;
    logic [T_DATA_WIDTH-1:0] acc_data [T_DATA_RATIO-1:0];
    logic [T_DATA_RATIO-1:0] acc_keep;

    logic [T_DATA_WIDTH-1:0] word_data [T_DATA_RATIO-1:0];
    logic [T_DATA_RATIO-1:0] word_keep;
    logic                    accept;
    logic                    close_word;

    assign s_ready_o  = rst_n && (!m_valid_o || m_ready_i);
    assign accept     = s_valid_i && s_ready_o;
    assign close_word = accept && ((idx == LAST_IDX) || s_last_i);

    // Accumulation buffer with the incoming beat merged in; lanes above idx are already zero.
    always_comb begin
        word_data = acc_data;
        word_keep = acc_keep;
        word_data[idx] = s_data_i;
        word_keep[idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx       <= '0;
            acc_keep  <= '0;
            m_keep_o  <= '0;
            m_last_o  <= 1'b0;
            m_valid_o <= 1'b0;
            for (int k = 0; k < T_DATA_RATIO; k++) begin
                acc_data[k] <= '0;
                m_data_o[k] <= '0;
            end
        end else begin
            if (m_valid_o && m_ready_i) begin
                m_valid_o <= 1'b0;
            end
            if (close_word) begin
                // A freshly loaded word overrides the clear from a same-edge transfer.
                m_data_o  <= word_data;
                m_keep_o  <= word_keep;
                m_last_o  <= s_last_i;
                m_valid_o <= 1'b1;
                idx       <= '0;
                acc_keep  <= '0;
                for (int k = 0; k < T_DATA_RATIO; k++) begin
                    acc_data[k] <= '0;
                end
            end else if (accept) begin
                acc_data[idx] <= s_data_i;
                acc_keep[idx] <= 1'b1;
                idx           <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stream_upsize.sv
// Directed table-driven bench for stream_upsize at 4-bit lanes, two lanes per word.
// Each table row is one clock: inputs, s_ready_o before the edge, outputs after it.
module tb_stream_upsize;

    logic       clk;
    logic       rst_n;
    logic [3:0] s_data;
    logic       s_last;
    logic       s_valid;
    logic       s_ready;
    logic [3:0] m_data [1:0];
    logic [1:0] m_keep;
    logic       m_last;
    logic       m_valid;
    logic       m_ready;

    int checks;
    int errors;

    stream_upsize #(
        .T_DATA_WIDTH(4),
        .T_DATA_RATIO(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data_i  (s_data),
        .s_last_i  (s_last),
        .s_valid_i (s_valid),
        .s_ready_o (s_ready),
        .m_data_o  (m_data),
        .m_keep_o  (m_keep),
        .m_last_o  (m_last),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst_n;
        logic       s_valid;
        logic [3:0] s_data;
        logic       s_last;
        logic       m_ready;
        logic       exp_ready;
        logic       exp_valid;
        logic       chk_word;
        logic [1:0] exp_keep;
        logic       exp_last;
        logic [3:0] exp_d0;
        logic [3:0] exp_d1;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input logic r, input logic v, input logic [3:0] d,
                                  input logic l, input logic mr);
        rst_n   = r;
        s_valid = v;
        s_data  = d;
        s_last  = l;
        m_ready = mr;
    endtask

    // Word fields are only meaningful while valid, except during reset where all must be zero.
    task automatic check_output(input string tag, input logic ev, input logic cw,
                                input logic [1:0] ek, input logic el,
                                input logic [3:0] e0, input logic [3:0] e1);
        check({tag, " m_valid"}, 32'(m_valid), 32'(ev));
        if (cw) begin
            check({tag, " m_keep"},  32'(m_keep),    32'(ek));
            check({tag, " m_last"},  32'(m_last),    32'(el));
            check({tag, " lane0"},   32'(m_data[0]), 32'(e0));
            check({tag, " lane1"},   32'(m_data[1]), 32'(e1));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        apply_stimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);

        //          rst v  data  lst mr  srdy vld chk keep   lst d0    d1
        vecs[0]  = '{1'b0, 1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 4'h0, 4'h0};
        vecs[1]  = '{1'b0, 1'b1, 4'h9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 4'h0, 4'h0};
        vecs[2]  = '{1'b1, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 4'h0, 4'h0};
        vecs[3]  = '{1'b1, 1'b1, 4'h1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 4'h0, 4'h1};
        vecs[4]  = '{1'b1, 1'b1, 4'h2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 4'h2, 4'h0};
        vecs[5]  = '{1'b1, 1'b1, 4'hA, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 4'h0, 4'h0};
        vecs[6]  = '{1'b1, 1'b0, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 4'h0, 4'h0};
        vecs[7]  = '{1'b1, 1'b1, 4'hB, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 1'b1, 4'hA, 4'hB};
        vecs[8]  = '{1'b1, 1'b1, 4'h8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 4'h0, 4'h0};
        vecs[9]  = '{1'b1, 1'b0, 4'h4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 4'h0, 4'h0};
        vecs[10] = '{1'b1, 1'b0, 4'h4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 4'h0, 4'h0};
        vecs[11] = '{1'b1, 1'b1, 4'h9, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 1'b1, 4'h8, 4'h9};

        step();
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(vecs[i].rst_n, vecs[i].s_valid, vecs[i].s_data,
                           vecs[i].s_last, vecs[i].m_ready);
            #1;
            check($sformatf("vec%0d s_ready", i), 32'(s_ready), 32'(vecs[i].exp_ready));
            step();
            check_output($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].chk_word,
                         vecs[i].exp_keep, vecs[i].exp_last, vecs[i].exp_d0, vecs[i].exp_d1);
        end

        // Backpressure: word {8,9} must hold and no beat may be taken.
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 1'b1, 4'(4'hC + i), 1'(i), 1'b0);
            #1;
            check($sformatf("stall%0d s_ready", i), 32'(s_ready), 32'd0);
            step();
            check_output($sformatf("stall%0d", i), 1'b1, 1'b1, 2'b11, 1'b1, 4'h8, 4'h9);
        end
        apply_stimulus(1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
        #1;
        check("release s_ready", 32'(s_ready), 32'd1);
        step();
        check_output("release", 1'b0, 1'b0, 2'b00, 1'b0, 4'h0, 4'h0);

        // Beats offered during the stall must not have been captured.
        apply_stimulus(1'b1, 1'b1, 4'hC, 1'b0, 1'b1);
        step();
        check_output("post-stall beat0", 1'b0, 1'b0, 2'b00, 1'b0, 4'h0, 4'h0);
        apply_stimulus(1'b1, 1'b1, 4'hD, 1'b0, 1'b1);
        step();
        check_output("post-stall word", 1'b1, 1'b1, 2'b11, 1'b0, 4'hC, 4'hD);

        // Reset mid-packet drops the partial beat 0x5.
        apply_stimulus(1'b1, 1'b1, 4'h5, 1'b0, 1'b1);
        step();
        check_output("partial 5", 1'b0, 1'b0, 2'b00, 1'b0, 4'h0, 4'h0);
        apply_stimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        #1;
        check("midreset s_ready", 32'(s_ready), 32'd0);
        step();
        check_output("midreset", 1'b0, 1'b1, 2'b00, 1'b0, 4'h0, 4'h0);
        apply_stimulus(1'b1, 1'b1, 4'h6, 1'b0, 1'b1);
        step();
        check_output("after reset beat6", 1'b0, 1'b0, 2'b00, 1'b0, 4'h0, 4'h0);
        apply_stimulus(1'b1, 1'b1, 4'h7, 1'b0, 1'b1);
        step();
        check_output("after reset word", 1'b1, 1'b1, 2'b11, 1'b0, 4'h6, 4'h7);
        apply_stimulus(1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
        step();
        check_output("drain", 1'b0, 1'b0, 2'b00, 1'b0, 4'h0, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
